// File: rtl/mux_arb_pkg.sv
// Shared types and the round-robin pick function for the four-requester arbiter.
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // First set bit of req, scanning from ptr upward with wrap-around; ptr if none.
    function automatic logic [SEL_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [SEL_W-1:0]   ptr
    );
        logic [SEL_W-1:0] idx;
        logic             found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ptr + SEL_W'(i);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/mux_4to1.sv
// Combinational 4:1 data selector used as the arbiter datapath.
module mux_4to1 #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic [WIDTH-1:0] in_d,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        out = in_a;
        case (sel)
            2'd0:    out = in_a;
            2'd1:    out = in_b;
            2'd2:    out = in_c;
            default: out = in_d;
        endcase
    end

endmodule

// File: rtl/mux_4to1_arbiter.sv
// Packet-aware round-robin arbiter feeding one registered valid/ready output stage.
// Optional per-grant beat limit enabled by defining MUX_ARB_HOLD_LIMIT_EN.
module mux_4to1_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_BEATS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic [WIDTH-1:0] in_d,
    input  logic [3:0]       valid,
    input  logic [3:0]       last,
    output logic [3:0]       ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       sel,
    output logic             busy
);

    // Empty block exists only to make an illegal limit visible at elaboration.
    if (MAX_BEATS < 2 || MAX_BEATS > 255) begin : g_max_beats_out_of_range
    end

    arb_state_t       state;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] sel_q;
    logic [WIDTH-1:0] mux_out;
    logic [WIDTH-1:0] out_p1;
    logic             vld_p1;
    logic             can_accept;
    logic             xfer;
    logic             release_grant;

    mux_4to1 #(
        .WIDTH (WIDTH)
    ) u_mux (
        .in_a (in_a),
        .in_b (in_b),
        .in_c (in_c),
        .in_d (in_d),
        .sel  (sel_q),
        .out  (mux_out)
    );

    // Ready looks only at the output register, never at valid/last.
    assign can_accept = !vld_p1 || out_ready;
    assign xfer       = (state == GRANT) && valid[sel_q] && can_accept;

    always_comb begin
        ready = '0;
        if (state == GRANT) begin
            ready[sel_q] = can_accept;
        end
    end

`ifdef MUX_ARB_HOLD_LIMIT_EN
    logic [7:0] beat_cnt;
    logic       limit_hit;

    assign limit_hit = (beat_cnt == 8'(MAX_BEATS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (state == IDLE) begin
            beat_cnt <= '0;
        end else if (xfer) begin
            beat_cnt <= beat_cnt + 8'd1;
        end
    end

    assign release_grant = xfer && (last[sel_q] || limit_hit);
`else
    assign release_grant = xfer && last[sel_q];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            sel_q <= '0;
        end else if (state == IDLE) begin
            if (|valid) begin
                sel_q <= rr_pick(valid, ptr);
                state <= GRANT;
            end
        end else begin
            if (release_grant) begin
                state <= IDLE;
                ptr   <= sel_q + 2'd1;
            end
        end
    end

    // ---- stage p1: registered output beat ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_p1 <= '0;
            vld_p1 <= 1'b0;
        end else if (xfer) begin
            out_p1 <= mux_out;
            vld_p1 <= 1'b1;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out       = out_p1;
    assign out_valid = vld_p1;
    assign sel       = sel_q;
    assign busy      = (state == GRANT);

endmodule

// File: tb/tb_mux_4to1_arbiter.sv
// Directed self-checking bench for mux_4to1_arbiter (hold-limit case under MUX_ARB_HOLD_LIMIT_EN).
module tb_mux_4to1_arbiter;

`ifdef MUX_ARB_HOLD_LIMIT_EN
    localparam int MB = 2;
`else
    localparam int MB = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in_a, in_b, in_c, in_d;
    logic [3:0] valid, last, ready;
    logic [3:0] out;
    logic       out_valid, out_ready;
    logic [1:0] sel;
    logic       busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux_4to1_arbiter #(
        .WIDTH     (4),
        .MAX_BEATS (MB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_d      (in_d),
        .valid     (valid),
        .last      (last),
        .ready     (ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid = 4'b0; last = 4'b0; out_ready = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        in_a = 4'h0; in_b = 4'h0; in_c = 4'h0; in_d = 4'h0;
        valid = 4'b0; last = 4'b0; out_ready = 1'b1;
        rst_n = 1'b0;
        #2;
        total++; if (out !== 4'h0) begin bad++; $display("FAIL reset_out got=%h want=0", out); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (ready !== 4'b0) begin bad++; $display("FAIL reset_ready got=%b want=0000", ready); end
        total++; if (sel !== 2'd0) begin bad++; $display("FAIL reset_sel got=%0d want=0", sel); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_d [5];
        exp_d = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};
        do_reset();
        in_a = 4'hA; in_b = 4'hB; in_c = 4'hC; in_d = 4'hD;
        valid = 4'b1111; last = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL rr_busy k=%0d got=%b want=1", k, busy); end
            total++; if (ready !== (4'b0001 << (k % 4))) begin bad++; $display("FAIL rr_ready k=%0d got=%b want=%b", k, ready, 4'b0001 << (k % 4)); end
            tick();
            total++; if (out !== exp_d[k] || out_valid !== 1'b1) begin bad++; $display("FAIL rr_out k=%0d got=%h/%b want=%h/1", k, out, out_valid, exp_d[k]); end
            total++; if (sel !== 2'(k % 4)) begin bad++; $display("FAIL rr_sel k=%0d got=%0d want=%0d", k, sel, k % 4); end
        end
        valid = 4'b0;
    endtask

    task automatic test_packet_hold();
        do_reset();
        in_b = 4'h1; in_c = 4'h9;
        valid = 4'b0110; last = 4'b0100; out_ready = 1'b1;
        tick();
        total++; if (sel !== 2'd1 || busy !== 1'b1) begin bad++; $display("FAIL hold_grant got sel=%0d busy=%b want sel=1 busy=1", sel, busy); end
        for (int k = 1; k <= 3; k++) begin
            total++; if (ready !== 4'b0010) begin bad++; $display("FAIL hold_ready beat=%0d got=%b want=0010", k, ready); end
            tick();
            total++; if (out !== 4'(k) || out_valid !== 1'b1) begin bad++; $display("FAIL hold_out beat=%0d got=%h/%b want=%h/1", k, out, out_valid, 4'(k)); end
            in_b = 4'(k + 1);
            if (k == 2) last = 4'b0110;
        end
        valid = 4'b0100;
        total++; if (busy !== 1'b0 || ready !== 4'b0) begin bad++; $display("FAIL hold_release got busy=%b ready=%b want 0/0000", busy, ready); end
        tick();
        total++; if (sel !== 2'd2) begin bad++; $display("FAIL hold_next_sel got=%0d want=2", sel); end
        tick();
        total++; if (out !== 4'h9) begin bad++; $display("FAIL hold_next_out got=%h want=9", out); end
        valid = 4'b0;
    endtask

    task automatic test_back_pressure();
        do_reset();
        in_c = 4'hC; valid = 4'b0100; last = 4'b0000; out_ready = 1'b1;
        tick();
        tick();
        total++; if (out !== 4'hC || out_valid !== 1'b1) begin bad++; $display("FAIL bp_first got=%h/%b want=c/1", out, out_valid); end
        out_ready = 1'b0; in_c = 4'h5; last = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++; if (ready !== 4'b0) begin bad++; $display("FAIL bp_ready cyc=%0d got=%b want=0000", k, ready); end
            tick();
            total++; if (out !== 4'hC || out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold cyc=%0d got=%h/%b want=c/1", k, out, out_valid); end
        end
        out_ready = 1'b1;
        #1;
        total++; if (ready !== 4'b0100) begin bad++; $display("FAIL bp_release_ready got=%b want=0100", ready); end
        tick();
        total++; if (out !== 4'h5 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_next got=%h/%b want=5/1", out, out_valid); end
        valid = 4'b0;
    endtask

    task automatic test_withdraw();
        do_reset();
        in_a = 4'h6; in_d = 4'hE;
        valid = 4'b1001; last = 4'b1000; out_ready = 1'b1;
        tick();
        tick();
        total++; if (out !== 4'h6 || sel !== 2'd0) begin bad++; $display("FAIL wd_first got out=%h sel=%0d want 6/0", out, sel); end
        valid = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (sel !== 2'd0 || busy !== 1'b1 || out_valid !== 1'b0 || ready !== 4'b0001) begin
                bad++; $display("FAIL wd_stall cyc=%0d got sel=%0d busy=%b ov=%b ready=%b want 0/1/0/0001", k, sel, busy, out_valid, ready);
            end
        end
        valid = 4'b1001; in_a = 4'h7; last = 4'b1001;
        tick();
        total++; if (out !== 4'h7 || out_valid !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL wd_resume got out=%h ov=%b busy=%b want 7/1/0", out, out_valid, busy); end
        tick();
        total++; if (sel !== 2'd3 || busy !== 1'b1) begin bad++; $display("FAIL wd_next_sel got=%0d busy=%b want 3/1", sel, busy); end
        valid = 4'b0;
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        in_c = 4'h3; valid = 4'b0100; last = 4'b0000; out_ready = 1'b1;
        tick();
        tick();
        total++; if (out !== 4'h3 || sel !== 2'd2) begin bad++; $display("FAIL rmp_pre got out=%h sel=%0d want 3/2", out, sel); end
        rst_n = 1'b0;
        #1;
        total++; if (out !== 4'h0 || out_valid !== 1'b0 || ready !== 4'b0 || sel !== 2'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL rmp_async got out=%h ov=%b ready=%b sel=%0d busy=%b want all 0", out, out_valid, ready, sel, busy);
        end
        tick();
        rst_n = 1'b1;
        tick();
        total++; if (sel !== 2'd2 || busy !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL rmp_regrant got sel=%0d busy=%b ov=%b want 2/1/0", sel, busy, out_valid); end
        tick();
        total++; if (out !== 4'h3 || out_valid !== 1'b1) begin bad++; $display("FAIL rmp_resend got=%h/%b want=3/1", out, out_valid); end
        valid = 4'b0;
    endtask

    task automatic test_hold_limit();
        logic [1:0] exp_sel  [6];
        logic       exp_busy [6];
`ifdef MUX_ARB_HOLD_LIMIT_EN
        exp_sel  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0};
        exp_busy = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_sel  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
        do_reset();
        in_a = 4'h2; in_b = 4'hB;
        valid = 4'b0011; last = 4'b0010; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            total++; if (sel !== exp_sel[k] || busy !== exp_busy[k]) begin
                bad++; $display("FAIL limit edge=%0d got sel=%0d busy=%b want sel=%0d busy=%b", k + 1, sel, busy, exp_sel[k], exp_busy[k]);
            end
        end
        valid = 4'b0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_packet_hold();
        test_back_pressure();
        test_withdraw();
        test_reset_mid_packet();
        test_hold_limit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_4to1_arbiter.md
# mux_4to1_arbiter

- Round-robin, packet-aware arbiter that shares one output channel among four requesters.
- Drives the select of an internal `mux_4to1` datapath and registers the selected beat into a single output stage with valid/ready handshake.
- Sits in front of any shared consumer that previously received a statically selected `mux_4to1` output.

## Interface
- `WIDTH`, default 4: data width of every input and of `out`.
- `MAX_BEATS`, default 8: beat limit per grant. Used only when `MUX_ARB_HOLD_LIMIT_EN` is defined; legal range 2–255.
- `clk` input, 1 bit: clock, rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_a`, `in_b`, `in_c`, `in_d` input, WIDTH bits each: requester data 0–3.
- `valid` input, 4 bits: per-requester beat valid; bit 0 = `in_a`.
- `last` input, 4 bits: per-requester final-beat flag, qualified by `valid`.
- `ready` output, 4 bits: per-requester accept; at most one bit high.
- `out` output, WIDTH bits: registered granted data.
- `out_valid` output, 1 bit: `out` holds a beat.
- `out_ready` input, 1 bit: consumer accepts `out`.
- `sel` output, 2 bits: index of the current or most recent grant.
- `busy` output, 1 bit: high in GRANT state.

## Operation
- **States:** IDLE and GRANT. A 2-bit round-robin pointer `ptr` names the highest-priority requester.
- **IDLE:**
  - If `valid` is nonzero, pick the first set bit scanning `ptr`, `ptr+1`, … mod 4.
  - Register the winner into `sel` and go to GRANT.
  - All `ready` bits are 0 while in IDLE.
  - With no `valid` bit set, stay in IDLE and hold `sel`.
- **GRANT:**
  - `ready[sel] = !out_valid || out_ready`; all other `ready` bits are 0.
  - A beat transfers when `valid[sel] && ready[sel]`.
  - The transferred beat loads `out` (the `mux_4to1` output) and sets `out_valid`.
- **Output stage:**
  - `out_valid` clears when `out_ready` is high and no new beat loads.
  - `out` holds its value while `out_valid && !out_ready`.
- **Release:**
  - A transfer with `last[sel]=1` returns the FSM to IDLE and sets `ptr = sel+1` mod 4.
  - `sel` keeps its value until the next grant.
- **Requester withdraws mid-packet** (`valid[sel]` low in GRANT): the grant is held and nothing transfers. No other requester may be granted until `last` arrives.
- **Simultaneous requests:** resolved only by `ptr` order. A lone requester regains the grant after one IDLE cycle.
- **Reset mid-packet:** all state clears immediately and the partial packet is dropped. The requester must resend the packet from its first beat.
- **Reset values:** `out=0`, `out_valid=0`, `ready=0`, `sel=0`, `busy=0`, `ptr=0`, state IDLE.

## Timing
- **Arbitration:** a request that is valid in IDLE at edge N gives `busy=1` and the new `sel` after N. The earliest `ready` is in cycle N+1.
- **Latency:** a beat transferred at edge M appears on `out` with `out_valid=1` after M, i.e. one cycle.
- **Throughput:** 1 beat per cycle within a packet when `out_ready` is held high.
- **Packet overhead:** each packet costs one IDLE cycle.
- **Back-pressure:**
  - `ready[sel]` depends combinationally on `out_ready` and `out_valid` only.
  - It has no combinational path from `valid` or `last`.

## Configuration
- `MUX_ARB_HOLD_LIMIT_EN` defined:
  - An 8-bit beat counter clears on each grant and increments on each transfer.
  - The transfer that reaches `MAX_BEATS` beats forces the return to IDLE and advances `ptr`, even with `last=0`.
  - The requester keeps `valid` asserted and continues its packet when next granted.
- `MUX_ARB_HOLD_LIMIT_EN` undefined: the counter is absent and the grant is released only on `last`.

## Structure
- **Package `mux_arb_pkg`:**
  - `NUM_REQ=4`.
  - `SEL_W=2`.
  - State enum `arb_state_t` {IDLE, GRANT}.
  - Function `rr_pick(req, ptr)` returning the 2-bit winner.
- **Sub-module:** one instance of the existing `mux_4to1`.
  - Ports: `in_a`..`in_d`, `sel`, `out`; parameter `WIDTH`.
  - Serves as the datapath feeding the output register. No other sub-modules.

## Test plan
- **Reset:** assert `rst_n=0` mid-packet -> all outputs read 0 in the same cycle; FSM returns to IDLE.
- **Round-robin order:** `in_a..d`=A,B,C,D; `valid=4'b1111`; `last=4'b1111` held; `out_ready=1` -> `out` sequence A,B,C,D,A, each beat 2 cycles apart.
- **Packet hold:** requester 1 sends 3 beats 1,2,3 with `last` on 3, while requester 2 stays valid -> `out`=1,2,3, then requester 2's data; `ready[2]=0` throughout requester 1's packet.
- **Back-pressure:** `out_ready=0` for 4 cycles with `out`=C -> `out` holds C, `ready=0`; release -> next beat appears 1 cycle later.
- **Withdraw:** `valid[0]` drops mid-packet while `valid[3]=1` -> no grant change and no beat on `out` until requester 0 resumes and sends `last`.
- **Hold limit** (`MUX_ARB_HOLD_LIMIT_EN`, `MAX_BEATS=2`): requester 0 sends 5 beats without `last` while requester 1 is valid -> grants alternate 0,0,1,…,0,0.
